// File: rtl/snake_nav_queue.sv
// snake_nav_queue
//   Per-player heading register with a small FIFO of pending turns. Rising
//   edges on the debounced direction buttons become turn requests. A request
//   is checked against the direction the snake will be travelling once every
//   turn already queued has been applied. A legal request is queued. One
//   queued turn is applied on each STEP_TICK.
//
// Ports
//   CLOCK        : system clock, rising edge
//   RESET        : synchronous, active-low reset
//   PUSH_BUTTONS : 4 bits per player {left, up, down, right}, level inputs
//   STEP_TICK    : one-cycle pulse, the game advances one cell
//   STATE_OUT    : 2 bits per player, 00 right, 01 down, 10 up, 11 left
//   DIR_CHANGED  : per-player pulse, aligned with the STATE_OUT update
//   REQ_DROPPED  : per-player pulse, a legal request was lost to a full FIFO
//   QUEUE_EMPTY  : per-player, FIFO holds no entries
//
// Handshake: none. Requests are fire-and-forget edges. STEP_TICK is a strobe
// that consumes at most one queued entry per player per cycle.
module snake_nav_queue #(
  parameter int         NUM_PLAYERS   = 2,
  parameter int         QUEUE_DEPTH   = 2,
  parameter bit         ALLOW_REVERSE = 1'b0,
  parameter logic [1:0] INIT_DIR      = 2'b00
) (
  input  logic                     CLOCK,
  input  logic                     RESET,
  input  logic [4*NUM_PLAYERS-1:0] PUSH_BUTTONS,
  input  logic                     STEP_TICK,
  output logic [2*NUM_PLAYERS-1:0] STATE_OUT,
  output logic [NUM_PLAYERS-1:0]   DIR_CHANGED,
  output logic [NUM_PLAYERS-1:0]   REQ_DROPPED,
  output logic [NUM_PLAYERS-1:0]   QUEUE_EMPTY
);

  localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(QUEUE_DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(QUEUE_DEPTH);

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    logic [3:0]    btn;
    logic [3:0]    prev;
    logic [3:0]    fresh;
    logic [1:0]    heading;
    logic [1:0]    mem [QUEUE_DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW-1:0] last_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_ap;
    logic          req_valid;
    logic [1:0]    req_dir;
    logic          pop;
    logic [1:0]    heading_next;
    logic [1:0]    ref_dir;
    logic          legal;
    logic          push;
    logic          drop;
    logic          changed_q;
    logic          dropped_q;

    assign btn = PUSH_BUTTONS[4*p +: 4];

    always_comb begin
      fresh     = btn & ~prev;
      req_valid = |fresh;
      // Lowest set bit wins, so only one request is taken per cycle.
      req_dir = 2'b00;
      if (fresh[0])      req_dir = 2'b00;
      else if (fresh[1]) req_dir = 2'b01;
      else if (fresh[2]) req_dir = 2'b10;
      else if (fresh[3]) req_dir = 2'b11;

      // The pop is resolved first, so a full FIFO that is popped this cycle
      // has room for a push in the same cycle.
      pop          = STEP_TICK && (count != '0);
      count_ap     = pop ? count - CW'(1) : count;
      heading_next = pop ? mem[head] : heading;

      // The youngest entry is the slot just behind the write pointer. The pop
      // does not move it unless the FIFO drains, in which case the heading
      // that is being written becomes the reference direction.
      last_ptr = (tail == '0) ? LAST_PTR : tail - PW'(1);
      ref_dir  = (count_ap != '0) ? mem[last_ptr] : heading_next;

      if (req_dir == ref_dir)       legal = 1'b0;
      else if (req_dir == ~ref_dir) legal = ALLOW_REVERSE;
      else                          legal = 1'b1;
      legal = legal && req_valid;

      push = legal && (count_ap != FULL_CNT);
      drop = legal && (count_ap == FULL_CNT);
    end

    always_ff @(posedge CLOCK) begin
      if (!RESET) begin
        prev      <= 4'b0000;
        heading   <= INIT_DIR;
        head      <= '0;
        tail      <= '0;
        count     <= '0;
        changed_q <= 1'b0;
        dropped_q <= 1'b0;
        for (int i = 0; i < QUEUE_DEPTH; i++) mem[i] <= 2'b00;
      end else begin
        prev      <= btn;
        heading   <= heading_next;
        changed_q <= pop;
        dropped_q <= drop;
        if (pop) head <= (head == LAST_PTR) ? '0 : head + PW'(1);
        if (push) begin
          mem[tail] <= req_dir;
          tail      <= (tail == LAST_PTR) ? '0 : tail + PW'(1);
        end
        count <= push ? count_ap + CW'(1) : count_ap;
      end
    end

    assign STATE_OUT[2*p +: 2] = heading;
    assign DIR_CHANGED[p]      = changed_q;
    assign REQ_DROPPED[p]      = dropped_q;
    assign QUEUE_EMPTY[p]      = (count == '0);
  end

endmodule

// File: tb/tb_snake_nav_queue.sv
// Directed bench for snake_nav_queue. It uses the default two-player build and
// a second single-player build that accepts reverse requests. Inputs change
// 1 time unit after a rising edge. Outputs are sampled 1 time unit after the
// next rising edge.
module tb_snake_nav_queue;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] buttons;
  logic [3:0] buttons_rev;
  logic       step_tick;
  logic [3:0] state_out;
  logic [1:0] dir_changed;
  logic [1:0] req_dropped;
  logic [1:0] queue_empty;
  logic [1:0] rev_state;
  logic       rev_changed;
  logic       rev_dropped;
  logic       rev_empty;

  int checks = 0;
  int fails  = 0;

  // Clock and reset
  always #5 clk = ~clk;

  snake_nav_queue #(
    .NUM_PLAYERS(2), .QUEUE_DEPTH(2), .ALLOW_REVERSE(1'b0), .INIT_DIR(2'b00)
  ) dut (
    .CLOCK(clk), .RESET(rst_n), .PUSH_BUTTONS(buttons), .STEP_TICK(step_tick),
    .STATE_OUT(state_out), .DIR_CHANGED(dir_changed),
    .REQ_DROPPED(req_dropped), .QUEUE_EMPTY(queue_empty)
  );

  snake_nav_queue #(
    .NUM_PLAYERS(1), .QUEUE_DEPTH(2), .ALLOW_REVERSE(1'b1), .INIT_DIR(2'b00)
  ) dut_rev (
    .CLOCK(clk), .RESET(rst_n), .PUSH_BUTTONS(buttons_rev), .STEP_TICK(step_tick),
    .STATE_OUT(rev_state), .DIR_CHANGED(rev_changed),
    .REQ_DROPPED(rev_dropped), .QUEUE_EMPTY(rev_empty)
  );

  // Driver tasks
  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; buttons = '0; buttons_rev = '0; step_tick = 1'b0;
    cyc(1);
    rst_n = 1'b1;
  endtask

  // Checker
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset with player 0 holding up through it
    rst_n = 1'b0; buttons = 8'b0000_0100; buttons_rev = '0; step_tick = 1'b0;
    cyc(2);
    check("rst_state",   {4'b0, state_out},   8'b0000_0000);
    check("rst_empty",   {6'b0, queue_empty}, 8'b0000_0011);
    check("rst_changed", {6'b0, dir_changed}, 8'b0);
    check("rst_dropped", {6'b0, req_dropped}, 8'b0);

    // Held button registers as a single press after reset is released
    rst_n = 1'b1;
    cyc(5);
    check("hold_queued", {6'b0, queue_empty}, 8'b0000_0010);
    check("hold_no_move", {4'b0, state_out},  8'b0000_0000);
    step_tick = 1'b1;
    cyc(1);
    check("hold_state",   {4'b0, state_out},   8'b0000_0010);
    check("hold_changed", {6'b0, dir_changed}, 8'b0000_0001);
    step_tick = 1'b0; buttons = '0;
    cyc(1);
    check("hold_pulse_end", {6'b0, dir_changed}, 8'b0);
    check("hold_drained",   {6'b0, queue_empty}, 8'b0000_0011);
    step_tick = 1'b1;
    cyc(1);
    check("hold_once_state",   {4'b0, state_out},   8'b0000_0010);
    check("hold_once_changed", {6'b0, dir_changed}, 8'b0);
    step_tick = 1'b0;

    // Double tap: up, release, left, then two ticks
    do_reset();
    buttons = 8'b0000_0100; cyc(1);
    buttons = 8'b0;         cyc(1);
    buttons = 8'b0000_1000; cyc(1);
    buttons = 8'b0;         cyc(1);
    step_tick = 1'b1;
    cyc(1);
    check("dtap_first",        {4'b0, state_out},   8'b0000_0010);
    check("dtap_first_pulse",  {6'b0, dir_changed}, 8'b0000_0001);
    check("dtap_not_empty",    {6'b0, queue_empty}, 8'b0000_0010);
    cyc(1);
    check("dtap_second",       {4'b0, state_out},   8'b0000_0011);
    check("dtap_second_pulse", {6'b0, dir_changed}, 8'b0000_0001);
    check("dtap_empty",        {6'b0, queue_empty}, 8'b0000_0011);
    step_tick = 1'b0;

    // Reverse and same-direction requests are filtered; reverse-enabled build queues left
    do_reset();
    buttons = 8'b0000_1000; buttons_rev = 4'b1000; cyc(1);
    buttons = 8'b0;         buttons_rev = 4'b0000; cyc(1);
    check("rev_drop_flag", {6'b0, req_dropped}, 8'b0);
    buttons = 8'b0000_0001; cyc(1);
    buttons = 8'b0;         cyc(1);
    check("rev_filtered",  {6'b0, queue_empty}, 8'b0000_0011);
    check("rev_no_drop",   {6'b0, req_dropped}, 8'b0);
    check("rev_allowed_q", {7'b0, rev_empty},   8'b0);
    step_tick = 1'b1;
    cyc(1);
    check("rev_allowed_state", {6'b0, rev_state},   8'b0000_0011);
    check("rev_blocked_state", {4'b0, state_out},   8'b0000_0000);
    check("rev_blocked_pulse", {6'b0, dir_changed}, 8'b0);
    step_tick = 1'b0;

    // Overflow: down, left, up with no tick
    do_reset();
    buttons = 8'b0000_0010; cyc(1);
    buttons = 8'b0;         cyc(1);
    buttons = 8'b0000_1000; cyc(1);
    buttons = 8'b0;         cyc(1);
    check("ovf_no_drop_yet", {6'b0, req_dropped}, 8'b0);
    buttons = 8'b0000_0100; cyc(1);
    check("ovf_drop",       {6'b0, req_dropped}, 8'b0000_0001);
    buttons = 8'b0;         cyc(1);
    check("ovf_drop_pulse", {6'b0, req_dropped}, 8'b0);
    // Reset while full discards the pending turns
    do_reset();
    cyc(1);
    check("mid_reset_empty", {6'b0, queue_empty}, 8'b0000_0011);
    step_tick = 1'b1;
    cyc(1);
    check("mid_reset_state", {4'b0, state_out}, 8'b0000_0000);
    step_tick = 1'b0;

    // Overflow repeat: third press coincides with a tick
    do_reset();
    buttons = 8'b0000_0010; cyc(1);
    buttons = 8'b0;         cyc(1);
    buttons = 8'b0000_1000; cyc(1);
    buttons = 8'b0;         cyc(1);
    buttons = 8'b0000_0100; step_tick = 1'b1; cyc(1);
    check("ovf_tick_state",   {4'b0, state_out},   8'b0000_0001);
    check("ovf_tick_changed", {6'b0, dir_changed}, 8'b0000_0001);
    check("ovf_tick_no_drop", {6'b0, req_dropped}, 8'b0);
    buttons = 8'b0;
    cyc(1);
    check("ovf_pop2", {4'b0, state_out}, 8'b0000_0011);
    check("ovf_pop2_not_empty", {6'b0, queue_empty}, 8'b0000_0010);
    cyc(1);
    check("ovf_pop3", {4'b0, state_out}, 8'b0000_0010);
    check("ovf_drained", {6'b0, queue_empty}, 8'b0000_0011);
    step_tick = 1'b0;

    // Independence and priority
    do_reset();
    buttons = 8'b0110_0100; cyc(1);
    check("indep_queued", {6'b0, queue_empty}, 8'b0);
    buttons = 8'b0; cyc(1);
    step_tick = 1'b1;
    cyc(1);
    check("indep_state",   {4'b0, state_out},   8'b0000_0110);
    check("indep_changed", {6'b0, dir_changed}, 8'b0000_0011);
    check("indep_empty",   {6'b0, queue_empty}, 8'b0000_0011);
    cyc(1);
    check("indep_stable",  {4'b0, state_out},   8'b0000_0110);
    step_tick = 1'b0;
    cyc(1);

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
